uart_apb_streamer: RTL
======================

UART_APB_STREAMER -- requirements
Module: uart_apb_streamer

Interface
REQ-001 SHALL have parameter BAUD_VALUE, default 1, meaning the 13-bit baud divisor written at init.
REQ-002 SHALL have parameter CTRL2_VALUE, default 8'h01, meaning the control-2 byte written at init (bit0 = 8-bit data, bit1 = parity enable, bit2 = odd parity).
REQ-003 SHALL have parameter TXF_DEPTH, default 4, meaning the TX FIFO depth, power of two, 2..16.
REQ-004 SHALL have PCLK, input, 1 bit: the one clock; all logic on its rising edge.
REQ-005 SHALL have PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have tx_data/tx_valid/tx_ready, in/in/out, 8/1/1 bits: upstream byte stream to transmit.
REQ-007 SHALL have rx_data/rx_valid/rx_ready, out/out/in, 8/1/1 bits: downstream received-byte stream.
REQ-008 SHALL have PADDR/PSEL/PENABLE/PWRITE/PWDATA, out, 5/1/1/1/8 bits: APB master request to the UART.
REQ-009 SHALL have PRDATA/PREADY/PSLVERR, in, 8/1/1 bits: APB completer response.
REQ-010 SHALL have TXRDY/RXRDY, in, 1/1 bits: UART sideband status.
REQ-011 SHALL have init_done, out, 1 bit: high once the block serves data; and apb_err, out, 1 bit: sticky, set on any PSLVERR.

Function
REQ-012 Register offsets SHALL be: TXDATA 5'h00, RXDATA 5'h04, CTRL1 5'h08, CTRL2 5'h0C.
REQ-013 APB FSM states SHALL be IDLE, SETUP (PSEL=1, PENABLE=0) and ACCESS (PSEL=1, PENABLE=1); the FSM holds ACCESS while PREADY=0 and returns to IDLE on PREADY=1.
REQ-014 PADDR, PWRITE and PWDATA SHALL be stable from SETUP through the completing ACCESS cycle; each transfer takes at least 2 cycles, and IDLE is held at least 1 cycle between transfers.
REQ-015 The TX FIFO SHALL accept a byte when tx_valid and tx_ready are both high; tx_ready = !full.
REQ-016 A TXDATA write SHALL start from IDLE when the FIFO is non-empty, TXRDY=1, tx holdoff=0 and no RX read is eligible; the FIFO pops on the write's completion.
REQ-017 An RXDATA read SHALL start from IDLE when RXRDY=1, the RX holding register is empty, and rx holdoff=0; PRDATA is captured into the holding register on completion and rx_valid rises the next cycle.
REQ-018 rx_valid SHALL stay high with rx_data stable until rx_ready=1, then clear.
REQ-019 When both a TX write and an RX read are eligible in IDLE, the RX read SHALL win.
REQ-020 After each TX write or RX read completes, its holdoff counter SHALL ignore TXRDY (respectively RXRDY) for 2 cycles, covering the UART status update latency.
REQ-021 On FIFO full, the push SHALL be refused (tx_ready=0) with no data loss; a simultaneous push and pop SHALL keep the count and keep order.
REQ-022 FIFO pointers SHALL wrap modulo TXF_DEPTH; the count SHALL be log2(TXF_DEPTH)+1 bits wide.
REQ-023 PSLVERR=1 on completion SHALL set apb_err; the transfer SHALL still be treated as complete, with no retry.

Reset
REQ-024 While PRESET=1, PSEL, PENABLE, PWRITE, tx_ready, rx_valid, init_done and apb_err SHALL be 0, PADDR, PWDATA and rx_data SHALL be 0, the FIFO SHALL be empty, holdoffs SHALL be 0 and the FSM SHALL be IDLE.
REQ-025 Reset asserted mid-transfer SHALL abort it at the next edge; the FIFO contents are discarded.
REQ-026 tx_ready SHALL rise no earlier than init_done.

Configuration
REQ-027 Macro UART_STREAMER_INIT_EN, when defined, SHALL make the block write CTRL1 = BAUD_VALUE[7:0] and then CTRL2 = {BAUD_VALUE[12:8], CTRL2_VALUE[2:0]} after reset, before serving data; init_done rises the cycle after the second write completes.
REQ-028 Without UART_STREAMER_INIT_EN, no configuration writes SHALL occur and init_done SHALL be 1 the first cycle after reset deasserts.

Verification
REQ-029 Bench SHALL cover: macro defined, BAUD_VALUE=1, CTRL2_VALUE=1 -> APB writes 08<=01 then 0C<=01; init_done is high 1 cycle later.
REQ-030 Bench SHALL cover: push 8'hA5 with TXRDY=1 and PREADY=1 -> write 00<=A5 takes exactly 2 cycles; no further write for 2 cycles even with TXRDY held high.
REQ-031 Bench SHALL cover: TXRDY=0 and push 5 bytes with TXF_DEPTH=4 -> tx_ready drops after the 4th; after TXRDY=1, writes occur in push order.
REQ-032 Bench SHALL cover: RXRDY=1, PRDATA=8'h3C, PREADY low for 3 cycles -> ACCESS lasts 4 cycles; rx_data=3C with rx_valid held until rx_ready.
REQ-033 Bench SHALL cover: RXRDY and TXRDY rise together with the FIFO non-empty -> the RXDATA read is issued before the TXDATA write.
REQ-034 Bench SHALL cover: PSLVERR=1 on a TX write -> apb_err=1 until PRESET, and the FIFO still pops.

Source files
------------

// File: rtl/uart_apb_streamer.sv
// Byte-stream bridge to an APB UART: TX FIFO drains into TXDATA writes, RXDATA reads feed rx stream.
// Define UART_STREAMER_INIT_EN to program CTRL1/CTRL2 from BAUD_VALUE/CTRL2_VALUE after reset.
module uart_apb_streamer #(
    parameter logic [12:0] BAUD_VALUE  = 13'd1,
    parameter logic [7:0]  CTRL2_VALUE = 8'h01,
    parameter int          TXF_DEPTH   = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic       TXRDY,
    input  logic       RXRDY,
    output logic       init_done,
    output logic       apb_err
);

    localparam int PTR_W = $clog2(TXF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TXF_DEPTH);

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;

    localparam logic [7:0] CTRL1_INIT = BAUD_VALUE[7:0];
    localparam logic [7:0] CTRL2_INIT = {BAUD_VALUE[12:8], CTRL2_VALUE[2:0]};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    typedef enum logic [1:0] {OP_TX, OP_RX, OP_CFG1, OP_CFG2} op_t;

    apb_state_t state_q, state_d;
    op_t        op_q, op_d;
    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [4:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;

    logic [7:0]       fifo_q [TXF_DEPTH];
    logic [7:0]       fifo_d [TXF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [1:0] tx_hold_q, tx_hold_d;
    logic [1:0] rx_hold_q, rx_hold_d;
    logic       init_done_q, init_done_d;
    logic       apb_err_q, apb_err_d;
`ifdef UART_STREAMER_INIT_EN
    logic       cfg_step_q, cfg_step_d;
`endif

    logic push, pop, rx_elig, tx_elig, cfg_req;

    assign tx_ready = init_done_q && (count_q != DEPTH_C);
    assign push     = tx_valid && tx_ready;
    assign rx_elig  = init_done_q && RXRDY && !rx_valid_q && (rx_hold_q == 2'd0);
    assign tx_elig  = init_done_q && (count_q != '0) && TXRDY && (tx_hold_q == 2'd0) && !rx_elig;
`ifdef UART_STREAMER_INIT_EN
    assign cfg_req  = !init_done_q;
`else
    assign cfg_req  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        apb_err_d  = apb_err_q;
        pop        = 1'b0;
        tx_hold_d  = (tx_hold_q != 2'd0) ? tx_hold_q - 2'd1 : 2'd0;
        rx_hold_d  = (rx_hold_q != 2'd0) ? rx_hold_q - 2'd1 : 2'd0;
`ifdef UART_STREAMER_INIT_EN
        cfg_step_d  = cfg_step_q;
        init_done_d = init_done_q;
`else
        init_done_d = 1'b1;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_req || rx_elig || tx_elig) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b1;
                    if (cfg_req) begin
`ifdef UART_STREAMER_INIT_EN
                        op_d     = cfg_step_q ? OP_CFG2 : OP_CFG1;
                        paddr_d  = cfg_step_q ? ADDR_CTRL2 : ADDR_CTRL1;
                        pwdata_d = cfg_step_q ? CTRL2_INIT : CTRL1_INIT;
`endif
                    end else if (rx_elig) begin
                        op_d     = OP_RX;
                        paddr_d  = ADDR_RXDATA;
                        pwdata_d = 8'h00;
                        pwrite_d = 1'b0;
                    end else begin
                        op_d     = OP_TX;
                        paddr_d  = ADDR_TXDATA;
                        pwdata_d = fifo_q[rd_ptr_q];
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A slave error still completes the transfer; it is only recorded.
                if (PREADY) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (PSLVERR) begin
                        apb_err_d = 1'b1;
                    end
                    case (op_q)
                        OP_TX: begin
                            pop       = 1'b1;
                            tx_hold_d = 2'd2;
                        end
                        OP_RX: begin
                            rx_data_d  = PRDATA;
                            rx_valid_d = 1'b1;
                            rx_hold_d  = 2'd2;
                        end
                        OP_CFG1: begin
`ifdef UART_STREAMER_INIT_EN
                            cfg_step_d = 1'b1;
`endif
                        end
                        OP_CFG2: begin
`ifdef UART_STREAMER_INIT_EN
                            init_done_d = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = tx_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            op_q        <= OP_TX;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 5'h00;
            pwdata_q    <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_hold_q   <= 2'd0;
            rx_hold_q   <= 2'd0;
            init_done_q <= 1'b0;
            apb_err_q   <= 1'b0;
`ifdef UART_STREAMER_INIT_EN
            cfg_step_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_hold_q   <= tx_hold_d;
            rx_hold_q   <= rx_hold_d;
            init_done_q <= init_done_d;
            apb_err_q   <= apb_err_d;
`ifdef UART_STREAMER_INIT_EN
            cfg_step_q  <= cfg_step_d;
`endif
        end
        // Storage needs no reset: the pointers and count define what is valid.
        fifo_q <= fifo_d;
    end

    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;
    assign apb_err   = apb_err_q;

endmodule
